lz77_job_scheduler: RTL and testbench

- Shares one lz77_compressor instance between NUM_REQ byte-stream requesters, one job at a time.
- Each job runs in four steps:
  - arbitrate with round-robin;
  - clear the compressor by pulsing its reset (its complete state is sticky);
  - pulse start, then feed exactly the requested byte count, marking the last byte;
  - forward the serial token bit stream tagged with the source ID, then wait for done.
- Sits between the host DMA/requester ports and the compressor.

---
 rtl/lz77_pkg.sv | 18 +
 rtl/lz77_rr_arbiter.sv | 45 ++++
 rtl/lz77_job_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_lz77_job_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 job scheduler and compressor slice.
package lz77_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStart,
        StFeed,
        StDrain,
        StFinish
    } sched_state_e;

    localparam int unsigned TOKEN_LIT_BITS   = 9;
    localparam int unsigned TOKEN_MATCH_BITS = 19;
    localparam int unsigned WINDOW_ADDR_BITS = 12;
    localparam int unsigned BUFFER_ADDR_BITS = 6;

endpackage

// File: rtl/lz77_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module lz77_rr_arbiter
    import lz77_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic             found_hi;
    logic             found_lo;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Scan downwards so the lowest set index wins, both overall and at/after ptr_i.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_lo = 1'b1;
                lo_idx   = IDX_W'(i);
                if (IDX_W'(i) >= ptr_i) begin
                    found_hi = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        any_o   = en_i & found_lo;
        idx_o   = found_hi ? hi_idx : lo_idx;
        grant_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/lz77_job_scheduler.sv
// Time-shares one LZ77 compressor between NUM_REQ byte-stream requesters, one job at a time.
// Optional stall watchdog enabled by defining LZ77_SCHED_WATCHDOG_EN.
module lz77_job_scheduler
    import lz77_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned CLR_CYCLES  = 2,
    parameter int unsigned WDOG_CYCLES = 65535,
    parameter int unsigned IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
    output logic [NUM_REQ-1:0]       req_grant_o,
    input  logic [NUM_REQ*8-1:0]     in_data_i,
    input  logic [NUM_REQ-1:0]       in_valid_i,
    output logic [NUM_REQ-1:0]       in_ready_o,
    output logic                     comp_rst_n_o,
    output logic                     comp_start_o,
    input  logic                     comp_done_i,
    output logic [7:0]               comp_data_o,
    output logic                     comp_valid_o,
    input  logic                     comp_ready_i,
    output logic                     comp_last_o,
    input  logic                     comp_bit_i,
    input  logic                     comp_bit_valid_i,
    output logic                     comp_bit_ready_o,
    output logic                     out_bit_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [IDX_W-1:0]         out_src_o,
    output logic                     job_done_o,
    output logic [31:0]              job_bits_o,
    output logic                     job_err_o
);

    sched_state_e        state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    rr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    sent_q;
    logic [31:0]         bits_q;
    logic [31:0]         clr_q;
    logic                comp_rst_n_q;
    logic                err_q;
`ifdef LZ77_SCHED_WATCHDOG_EN
    logic [31:0]         stall_q;
`endif

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [LEN_W-1:0]    arb_len;
    logic [7:0]          sel_data;
    logic                sel_valid;
    logic                feeding;
    logic                bit_path;
    logic                last_byte;
    logic                byte_xfer;
    logic                bit_xfer;

    lz77_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (rr_q),
        .en_i    (state_q == StIdle),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        arb_len   = '0;
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) arb_len = req_len_i[i*LEN_W +: LEN_W];
            if (idx_q == IDX_W'(i)) begin
                sel_data  = in_data_i[i*8 +: 8];
                sel_valid = in_valid_i[i];
            end
        end
    end

    assign feeding   = (state_q == StFeed);
    assign bit_path  = feeding || (state_q == StDrain);
    assign last_byte = (sent_q == len_q - 1'b1);
    assign byte_xfer = feeding && sel_valid && comp_ready_i;
    assign bit_xfer  = bit_path && comp_bit_valid_i && out_ready_i;

    always_comb begin
        in_ready_o   = '0;
        comp_data_o  = '0;
        comp_valid_o = 1'b0;
        comp_last_o  = 1'b0;
        if (feeding) begin
            in_ready_o[idx_q] = comp_ready_i;
            comp_data_o       = sel_data;
            comp_valid_o      = sel_valid;
            comp_last_o       = last_byte;
        end
    end

    assign out_bit_o        = bit_path & comp_bit_i;
    assign out_valid_o      = bit_path & comp_bit_valid_i;
    assign comp_bit_ready_o = bit_path & out_ready_i;
    assign comp_start_o     = (state_q == StStart);
    assign job_done_o       = (state_q == StFinish);
    assign job_err_o        = job_done_o & err_q;
    assign comp_rst_n_o     = comp_rst_n_q;
    assign req_grant_o      = grant_q;
    assign out_src_o        = idx_q;
    assign job_bits_o       = bits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            idx_q        <= '0;
            rr_q         <= '0;
            len_q        <= '0;
            sent_q       <= '0;
            bits_q       <= '0;
            clr_q        <= '0;
            comp_rst_n_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef LZ77_SCHED_WATCHDOG_EN
            stall_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    comp_rst_n_q <= 1'b0;
                    err_q        <= 1'b0;
                    if (arb_any) begin
                        grant_q <= arb_grant;
                        idx_q   <= arb_idx;
                        len_q   <= arb_len;
                        sent_q  <= '0;
                        bits_q  <= '0;
                        clr_q   <= '0;
                        // Zero-length jobs never touch the compressor.
                        if (arb_len == '0) begin
                            err_q   <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            state_q <= StClear;
                        end
                    end
                end
                StClear: begin
                    if (clr_q == 32'(CLR_CYCLES - 1)) begin
                        comp_rst_n_q <= 1'b1;
                        state_q      <= StStart;
                    end else begin
                        clr_q <= clr_q + 1'b1;
                    end
                end
                StStart: state_q <= StFeed;
                StFeed: begin
                    if (byte_xfer) begin
                        sent_q <= sent_q + 1'b1;
                        if (last_byte) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (comp_done_i) state_q <= StFinish;
                end
                StFinish: begin
                    grant_q <= '0;
                    rr_q    <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (bit_xfer && (bits_q != '1)) bits_q <= bits_q + 1'b1;

`ifdef LZ77_SCHED_WATCHDOG_EN
            // Any handshake counts as progress; otherwise abort after WDOG_CYCLES idle cycles.
            if (!bit_path || byte_xfer || bit_xfer) begin
                stall_q <= '0;
            end else if (stall_q == 32'(WDOG_CYCLES - 1)) begin
                stall_q <= '0;
                err_q   <= 1'b1;
                state_q <= StFinish;
            end else begin
                stall_q <= stall_q + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lz77_job_scheduler.sv
// Scoreboard bench for lz77_job_scheduler with a behavioural compressor that emits 9 bits per byte.
module tb_lz77_job_scheduler;

    localparam int NR     = 4;
    localparam int LW     = 16;
    localparam int CLR    = 2;
    localparam int BUDGET = 5000;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } byte_exp_t;

    typedef struct {
        int   src;
        int   bits;
        logic err;
    } job_exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*LW-1:0] req_len;
    logic [NR-1:0]    req_grant;
    logic [NR*8-1:0]  in_data;
    logic [NR-1:0]    in_valid;
    logic [NR-1:0]    in_ready;
    logic             comp_rst_n, comp_start, comp_done;
    logic [7:0]       comp_data;
    logic             comp_valid, comp_ready, comp_last;
    logic             comp_bit, comp_bit_valid, comp_bit_ready;
    logic             out_bit, out_valid, out_ready;
    logic [1:0]       out_src;
    logic             job_done, job_err;
    logic [31:0]      job_bits;

    int total = 0;
    int bad   = 0;
    int n_start = 0, n_done = 0, n_bytes = 0;
    bit rnd = 1'b0;
    bit abort = 1'b0;

    int        exp_grant_q[$];
    byte_exp_t exp_byte_q[$];
    job_exp_t  job_q[$];

    lz77_job_scheduler #(
        .NUM_REQ     (NR),
        .LEN_W       (LW),
        .CLR_CYCLES  (CLR),
        .WDOG_CYCLES (100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_len_i        (req_len),
        .req_grant_o      (req_grant),
        .in_data_i        (in_data),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .comp_rst_n_o     (comp_rst_n),
        .comp_start_o     (comp_start),
        .comp_done_i      (comp_done),
        .comp_data_o      (comp_data),
        .comp_valid_o     (comp_valid),
        .comp_ready_i     (comp_ready),
        .comp_last_o      (comp_last),
        .comp_bit_i       (comp_bit),
        .comp_bit_valid_i (comp_bit_valid),
        .comp_bit_ready_o (comp_bit_ready),
        .out_bit_o        (out_bit),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_src_o        (out_src),
        .job_done_o       (job_done),
        .job_bits_o       (job_bits),
        .job_err_o        (job_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected or bound expired", name);
    endtask

    function automatic logic pat(input int k);
        return k[0] ^ k[2] ^ k[5];
    endfunction

    function automatic logic [7:0] byte_at(input int kind, input int r, input int i);
        case (kind)
            0:       return 8'h61 + 8'(i % 3);  // "abcab..."
            1:       return 8'h61;              // "aaaa..."
            default: return 8'(i * 7 + r);
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, 32'(req_grant), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_comp_rst_n"}, 32'(comp_rst_n), 0);
        chk({tag, "_comp_start"}, 32'(comp_start), 0);
        chk({tag, "_comp_valid"}, 32'(comp_valid), 0);
        chk({tag, "_comp_last"}, 32'(comp_last), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_bit_ready"}, 32'(comp_bit_ready), 0);
        chk({tag, "_job_done"}, 32'(job_done), 0);
        chk({tag, "_job_err"}, 32'(job_err), 0);
        chk({tag, "_job_bits"}, job_bits, 0);
        chk({tag, "_out_src"}, 32'(out_src), 0);
    endtask

    // Requester: raise request, push expectations on grant, then stream len bytes.
    task automatic do_job(input int r, input int len, input int kind, input bit keep);
        int        t;
        int        sent;
        bit        x;
        byte_exp_t be;
        job_exp_t  je;
        t = 0;
        while (req_grant[r] && t < BUDGET) begin
            @(posedge clk); #1; t++;
        end
        req_len[r*LW +: LW] = 16'(len);
        req_valid[r] = 1'b1;
        while (!req_grant[r] && !abort && t < BUDGET) begin
            @(posedge clk); #1; t++;
        end
        if (!req_grant[r]) begin
            if (!abort) fail_now("grant_timeout");
            req_valid[r] = 1'b0;
            return;
        end
        je.src  = r;
        je.bits = 9 * len;
        je.err  = (len == 0);
        job_q.push_back(je);
        for (int i = 0; i < len; i++) begin
            be.data = byte_at(kind, r, i);
            be.last = (i == len - 1);
            exp_byte_q.push_back(be);
        end
        if (!keep) req_valid[r] = 1'b0;
        sent = 0;
        while (sent < len && !abort && t < BUDGET) begin
            in_data[r*8 +: 8] = byte_at(kind, r, sent);
            in_valid[r] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            x = in_valid[r] && in_ready[r];
            @(posedge clk); #1; t++;
            if (x) sent++;
        end
        in_valid[r] = 1'b0;
        if (sent < len && !abort) fail_now("feed_timeout");
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((job_q.size() != 0 || req_grant != 0) && t < BUDGET) begin
            @(posedge clk); #1; t++;
        end
        if (t >= BUDGET) fail_now("idle_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Behavioural compressor: counts bytes up to comp_last, then emits 9 bits per byte.
    initial begin : comp_model
        int nrx, pending, k;
        bit bx, lx, tx, rn;
        nrx = 0; pending = 0; k = 0;
        forever begin
            @(negedge clk);
            bx = comp_valid && comp_ready;
            lx = bx && comp_last;
            tx = comp_bit_valid && comp_bit_ready;
            rn = comp_rst_n;
            @(posedge clk); #1;
            if (!rn) begin
                nrx = 0; pending = 0; k = 0;
            end else begin
                if (bx) nrx++;
                if (lx) pending = 9 * nrx;
                if (tx) k++;
            end
            comp_bit_valid = (pending > 0) && (k < pending);
            comp_bit       = pat(k);
            comp_done      = (pending > 0) && (k == pending);
            comp_ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        logic [NR-1:0] prev_g;
        int            bitpos, clr_lo, cur_src, eg;
        byte_exp_t     be;
        job_exp_t      je;
        prev_g = '0; bitpos = 0; clr_lo = 0; cur_src = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_g = '0; bitpos = 0; clr_lo = 0;
                continue;
            end
            chk("grant_onehot", 32'($countones(req_grant) <= 1), 1);
            if (req_grant != 0 && prev_g == 0) begin
                if (exp_grant_q.size() == 0) begin
                    fail_now("grant_unexpected");
                end else begin
                    eg = exp_grant_q.pop_front();
                    cur_src = eg;
                    chk("grant_order", 32'(req_grant), 32'(1) << eg);
                end
            end
            prev_g = req_grant;
            if (req_grant != 0 && !comp_rst_n) clr_lo++;
            if (comp_start) begin
                n_start++;
                chk("clear_low_cycles", clr_lo, CLR);
                chk("start_rst_high", 32'(comp_rst_n), 1);
                clr_lo = 0;
            end
            if (comp_valid && comp_ready) begin
                n_bytes++;
                if (exp_byte_q.size() == 0) begin
                    fail_now("byte_unexpected");
                end else begin
                    be = exp_byte_q.pop_front();
                    chk("byte_data", 32'(comp_data), 32'(be.data));
                    chk("byte_last", 32'(comp_last), 32'(be.last));
                end
            end
            if (out_valid) chk("bit_ready_track", 32'(comp_bit_ready), 32'(out_ready));
            if (out_valid && out_ready) begin
                chk("bit_value", 32'(out_bit), 32'(pat(bitpos)));
                chk("bit_src", 32'(out_src), cur_src);
                bitpos++;
            end
            if (job_done) begin
                n_done++;
                if (job_q.size() == 0) begin
                    fail_now("job_done_unexpected");
                end else begin
                    je = job_q.pop_front();
                    chk("job_bits", job_bits, je.bits);
                    chk("job_err", 32'(job_err), 32'(je.err));
                    chk("job_src", 32'(out_src), je.src);
                    chk("accepted_bits", bitpos, je.bits);
                    chk("finish_comp_rst", 32'(comp_rst_n), 32'(!je.err));
                end
                bitpos = 0;
                clr_lo = 0;
            end else if (job_err) begin
                fail_now("job_err_without_done");
            end
        end
    end

    initial begin : stim
        int s0, d0, b0, t;
        rst_n = 1'b0;
        req_valid = '0; req_len = '0; in_data = '0; in_valid = '0;
        comp_done = 1'b0; comp_ready = 1'b1; comp_bit = 1'b0;
        comp_bit_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst_n = 1'b1;

        // All four requesters, req 0 stays valid and is served again after the wrap.
        exp_grant_q = '{0, 1, 2, 3, 0};
        fork
            begin
                do_job(0, 3, 2, 1'b1);
                do_job(0, 3, 2, 1'b0);
            end
            do_job(1, 3, 2, 1'b0);
            do_job(2, 3, 2, 1'b0);
            do_job(3, 3, 2, 1'b0);
        join
        wait_idle();

        s0 = n_start;
        exp_grant_q.push_back(0);
        do_job(0, 5, 0, 1'b0);
        wait_idle();
        chk("single_start_count", n_start - s0, 1);

        s0 = n_start;
        exp_grant_q.push_back(2);
        do_job(2, 0, 2, 1'b0);
        wait_idle();
        chk("zero_len_no_start", n_start - s0, 0);
        chk("zero_len_grant_idle", 32'(req_grant), 0);

        rnd = 1'b1;
        exp_grant_q.push_back(3);
        do_job(3, 40, 1, 1'b0);
        wait_idle();
        rnd = 1'b0;

        // Asynchronous reset once 7 of 20 bytes have gone through.
        exp_grant_q.push_back(1);
        b0 = n_bytes;
        d0 = n_done;
        fork
            do_job(1, 20, 2, 1'b0);
            begin
                t = 0;
                while (n_bytes - b0 < 7 && t < BUDGET) begin
                    @(posedge clk); #2; t++;
                end
                if (t >= BUDGET) fail_now("reset_point_timeout");
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                chk_reset("mid_reset");
            end
        join
        job_q.delete();
        exp_byte_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_on_abort", n_done, d0);
        abort = 1'b0;
        rst_n = 1'b1;
        exp_grant_q.push_back(1);
        do_job(1, 20, 2, 1'b0);
        wait_idle();
        chk("rerequest_done", n_done, d0 + 1);
        chk("grant_queue_drained", exp_grant_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
